usb_tx_sequencer: RTL and testbench

Transmit-side sequencer for the USB full-speed TX path. It accepts a packet start command, pulls bytes from the TX byte source over a valid/ready handshake, and serialises them LSB-first at one bit per BIT_CLKS clocks. It inserts stall bit-times on request from the bit stuffer and finishes every packet with an EOP (SE0, SE0, J). It sits between the TX FIFO/packet builder and the bit-stuffer/NRZI encoder, and owns all bit-time and bit-count sequencing.

---
 rtl/usb_tx_pkg.sv | 19 +
 rtl/usb_tx_bit_timer.sv | 29 ++
 rtl/usb_tx_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed TX sequencer.
// Optional TX_UNDERRUN_ABORT_EN is consumed by usb_tx_sequencer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STUFF,
        S_EOP_SE0,
        S_EOP_J,
        S_DONE
    } tx_state_t;

    localparam int EOP_SE0_BITS = 2;
    localparam int EOP_J_BITS   = 1;
    localparam int BYTE_BITS    = 8;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-time counter: counts 1..BIT_CLKS while enabled and strobes on
// the last clock of each bit time; clear restarts a bit time at 1.
module usb_tx_bit_timer #(
    parameter int BIT_CLKS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic bit_strobe
);

    logic [3:0] cnt_q;

    assign bit_strobe = (cnt_q == 4'(BIT_CLKS));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= 4'd0;
        end else if (clr) begin
            cnt_q <= 4'd1;
        end else if (en) begin
            cnt_q <= bit_strobe ? 4'd1 : cnt_q + 4'd1;
        end else begin
            cnt_q <= 4'd0;
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB FS transmit sequencer: byte fetch, LSB-first serialisation, stall
// bits and EOP. Define TX_UNDERRUN_ABORT_EN to flag underruns on tx_error.
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int BIT_CLKS = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       stuff_req,
    output logic       tx_bit,
    output logic       se0,
    output logic       bit_strobe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       last_q, last_d;
    logic [7:0] stg_data_q, stg_data_d;
    logic       stg_last_q, stg_last_d;
    logic       stg_valid_q, stg_valid_d;
    logic [1:0] eop_cnt_q, eop_cnt_d;
    logic [1:0] se0_bits_q, se0_bits_d;
    logic       tmr_clr, tmr_en;
    logic       prefetch, accept, advance, in_bit;
    logic       underrun;

    usb_tx_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .bit_strobe(bit_strobe)
    );

    assign in_bit   = (state_q == S_SHIFT) || (state_q == S_STUFF);
    assign tmr_en   = in_bit || (state_q == S_EOP_SE0)
                      || (state_q == S_EOP_J);
    assign prefetch = in_bit && (idx_q == 3'(BYTE_BITS - 1))
                      && !last_q && !stg_valid_q;
    assign byte_ready = (state_q == S_LOAD) || prefetch;
    assign accept     = byte_ready && byte_valid;
    // A stuff bit finishes like an ordinary data bit would have.
    assign advance = bit_strobe
                     && ((state_q == S_STUFF)
                         || ((state_q == S_SHIFT) && !stuff_req));

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        last_d      = last_q;
        stg_data_d  = stg_data_q;
        stg_last_d  = stg_last_q;
        stg_valid_d = stg_valid_q;
        eop_cnt_d   = eop_cnt_q;
        se0_bits_d  = se0_bits_q;
        tmr_clr     = 1'b0;
        underrun    = 1'b0;
        if (prefetch && accept) begin
            stg_data_d  = byte_data;
            stg_last_d  = byte_last;
            stg_valid_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (tx_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    shift_d = byte_data;
                    last_d  = byte_last;
                    idx_d   = 3'd0;
                    tmr_clr = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT, S_STUFF: begin
                if (bit_strobe && state_q == S_SHIFT && stuff_req) begin
                    state_d = S_STUFF;
                end else if (advance) begin
                    state_d = S_SHIFT;
                    if (idx_q != 3'(BYTE_BITS - 1)) begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end else if (last_q) begin
                        state_d    = S_EOP_SE0;
                        eop_cnt_d  = 2'd0;
                        se0_bits_d = 2'(EOP_SE0_BITS);
                    end else if (stg_valid_q) begin
                        shift_d     = stg_data_q;
                        last_d      = stg_last_q;
                        idx_d       = 3'd0;
                        stg_valid_d = 1'b0;
                    end else if (accept) begin
                        // Byte arriving on the boundary strobe bypasses staging.
                        shift_d     = byte_data;
                        last_d      = byte_last;
                        idx_d       = 3'd0;
                        stg_valid_d = 1'b0;
                    end else begin
                        underrun  = 1'b1;
                        state_d   = S_EOP_SE0;
                        eop_cnt_d = 2'd0;
`ifdef TX_UNDERRUN_ABORT_EN
                        se0_bits_d = 2'd1;
`else
                        se0_bits_d = 2'(EOP_SE0_BITS);
`endif
                    end
                end
            end
            S_EOP_SE0: begin
                if (bit_strobe) begin
                    if (eop_cnt_q == se0_bits_q - 2'd1) begin
                        state_d   = S_EOP_J;
                        eop_cnt_d = 2'd0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (bit_strobe) begin
                    if (eop_cnt_q == 2'(EOP_J_BITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            shift_q     <= 8'h00;
            idx_q       <= 3'd0;
            last_q      <= 1'b0;
            stg_data_q  <= 8'h00;
            stg_last_q  <= 1'b0;
            stg_valid_q <= 1'b0;
            eop_cnt_q   <= 2'd0;
            se0_bits_q  <= 2'(EOP_SE0_BITS);
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            stg_data_q  <= stg_data_d;
            stg_last_q  <= stg_last_d;
            stg_valid_q <= stg_valid_d;
            eop_cnt_q   <= eop_cnt_d;
            se0_bits_q  <= se0_bits_d;
        end
    end

    always_comb begin
        tx_bit = 1'b1;
        unique case (1'b1)
            (state_q == S_SHIFT):   tx_bit = shift_q[0];
            (state_q == S_STUFF):   tx_bit = 1'b0;
            (state_q == S_EOP_SE0): tx_bit = 1'b0;
            default:                tx_bit = 1'b1;
        endcase
    end

    assign se0     = (state_q == S_EOP_SE0);
    assign tx_busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign tx_done = (state_q == S_DONE);

`ifdef TX_UNDERRUN_ABORT_EN
    assign tx_error = underrun;
`else
    assign tx_error = 1'b0;
    logic unused_underrun;
    assign unused_underrun = underrun;
`endif

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: waveforms compared cycle by cycle
// against a bit-segment model built from hand-chosen packets.
module tb_usb_tx_sequencer;

    localparam int BC = 8;
`ifdef TX_UNDERRUN_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;
    logic       stuff_req = 1'b0;
    logic       byte_ready, tx_bit, se0, bit_strobe;
    logic       tx_busy, tx_done, tx_error;

    int checks = 0;
    int errors = 0;

    usb_tx_sequencer #(.BIT_CLKS(BC)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_start  (tx_start),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_last (byte_last),
        .byte_ready(byte_ready),
        .stuff_req (stuff_req),
        .tx_bit    (tx_bit),
        .se0       (se0),
        .bit_strobe(bit_strobe),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] q_data[$];
    logic       q_last[$];
    logic       r_bit[$], r_se0[$], r_stb[$], r_done[$], r_rdy[$], r_err[$];
    logic       seg_bit[$], seg_se0[$];
    int         base;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        q_data.push_back(b);
        q_last.push_back(last);
    endtask

    task automatic seg_byte(input logic [7:0] b, input int stuff_at);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < 8; i++) begin
            seg_bit.push_back(v[i]);
            seg_se0.push_back(1'b0);
            if (seg_bit.size() - 1 == stuff_at) begin
                seg_bit.push_back(1'b0);
                seg_se0.push_back(1'b0);
            end
        end
    endtask

    task automatic seg_eop(input int n_se0);
        for (int i = 0; i < n_se0; i++) begin
            seg_bit.push_back(1'b0);
            seg_se0.push_back(1'b1);
        end
        seg_bit.push_back(1'b1);
        seg_se0.push_back(1'b0);
    endtask

    task automatic run_pkt(input int stuff_at, input bit hold,
                           input int rst_at, input int max_cyc);
        int  nstb;
        bit  got_done;
        bit  hs;
        nstb = 0;
        got_done = 1'b0;
        base = -1;
        r_bit.delete(); r_se0.delete(); r_stb.delete();
        r_done.delete(); r_rdy.delete(); r_err.delete();
        tx_start = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            byte_valid = (q_data.size() != 0);
            byte_data  = byte_valid ? q_data[0] : 8'h00;
            byte_last  = byte_valid ? q_last[0] : 1'b0;
            stuff_req  = bit_strobe && (nstb == stuff_at);
            r_bit.push_back(tx_bit);
            r_se0.push_back(se0);
            r_stb.push_back(bit_strobe);
            r_done.push_back(tx_done);
            r_rdy.push_back(byte_ready);
            r_err.push_back(tx_error);
            if (bit_strobe) nstb++;
            if (c == rst_at) begin
                #2 n_rst = 1'b0;
                #1;
                check("rst_tx_bit", tx_bit, 1);
                check("rst_se0", se0, 0);
                check("rst_busy", tx_busy, 0);
                check("rst_ready", byte_ready, 0);
                q_data.delete();
                q_last.delete();
                tx_start = 1'b0;
                byte_valid = 1'b0;
                stuff_req = 1'b0;
                tick;
                n_rst = 1'b1;
                tick;
                return;
            end
            if (tx_done) begin
                got_done = 1'b1;
                tx_start = 1'b0;
                byte_valid = 1'b0;
                stuff_req = 1'b0;
                tick;
                break;
            end
            hs = byte_ready && byte_valid;
            @(posedge clk);
            if (hs) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
                if (base < 0) base = c + 1;
            end
            #1;
            if (!hold) tx_start = 1'b0;
        end
        check("done_seen", got_done, 1);
    endtask

    task automatic check_wave(input string nm, input int err_seg);
        int nseg, idx, s, n;
        bit ph_end;
        nseg = seg_bit.size();
        check({nm, "_start_lat"}, base, 2);
        check({nm, "_length"}, r_done.size(), base + nseg * BC + 1);
        n = r_done.size();
        for (int k = 0; k < n; k++) begin
            if (k < base) begin
                check({nm, "_pre_done"}, r_done[k], 0);
                check({nm, "_pre_bit"}, r_bit[k], 1);
                continue;
            end
            idx = k - base;
            s = idx / BC;
            ph_end = (idx % BC) == BC - 1;
            check({nm, "_done"}, r_done[k], idx == nseg * BC);
            check({nm, "_stb"}, r_stb[k], (s < nseg) && ph_end);
            check({nm, "_se0"}, r_se0[k], (s < nseg) && seg_se0[s]);
            check({nm, "_err"}, r_err[k], ABORT && (s == err_seg) && ph_end);
            if (s >= nseg || !seg_se0[s])
                check({nm, "_bit"}, r_bit[k], (s < nseg) ? seg_bit[s] : 1'b1);
        end
        seg_bit.delete();
        seg_se0.delete();
    endtask

    initial begin
        int cnt;
        tick;
        tick;
        check("reset_tx_bit", tx_bit, 1);
        check("reset_se0", se0, 0);
        check("reset_ready", byte_ready, 0);
        check("reset_strobe", bit_strobe, 0);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);
        check("reset_error", tx_error, 0);
        n_rst = 1'b1;
        tick;
        tick;
        check("idle_bit", tx_bit, 1);

        // Single byte 0xA5, last
        push_byte(8'hA5, 1'b1);
        run_pkt(-1, 1'b0, -1, 300);
        check("a5_done_at_88", r_done.size() - 1 - base, 88);
        seg_byte(8'hA5, -1);
        seg_eop(2);
        check_wave("a5", -1);
        tick;

        // Two contiguous bytes with valid always high
        push_byte(8'h01, 1'b0);
        push_byte(8'h80, 1'b1);
        run_pkt(-1, 1'b0, -1, 400);
        cnt = 0;
        for (int k = base; k < r_rdy.size(); k++) begin
            check("two_ready", r_rdy[k], k == base + 7 * BC);
            if (k < base + 16 * BC && r_stb[k]) cnt++;
        end
        check("two_data_strobes", cnt, 16);
        seg_byte(8'h01, -1);
        seg_byte(8'h80, -1);
        seg_eop(2);
        check_wave("two", -1);
        tick;

        // Stuff after bit 2 of 0xFF
        push_byte(8'hFF, 1'b1);
        run_pkt(2, 1'b0, -1, 300);
        seg_byte(8'hFF, 2);
        seg_eop(2);
        check("stuff_segments", seg_bit.size(), 12);
        check_wave("stuff", -1);
        tick;

        // Underrun: second byte never arrives
        push_byte(8'h3C, 1'b0);
        run_pkt(-1, 1'b0, -1, 300);
        seg_byte(8'h3C, -1);
        seg_eop(ABORT ? 1 : 2);
        check_wave("underrun", 7);
        tick;

        // tx_start held, reset pulsed at bit 7 of the first byte
        push_byte(8'h33, 1'b0);
        push_byte(8'h44, 1'b1);
        run_pkt(-1, 1'b1, 2 + 7 * BC + 4, 300);
        cnt = 0;
        foreach (r_done[k]) if (r_done[k] || r_err[k]) cnt++;
        check("rst_no_done", cnt, 0);
        check("post_rst_busy", tx_busy, 0);
        check("post_rst_bit", tx_bit, 1);

        push_byte(8'h96, 1'b0);
        push_byte(8'h69, 1'b1);
        run_pkt(-1, 1'b1, -1, 400);
        seg_byte(8'h96, -1);
        seg_byte(8'h69, -1);
        seg_eop(2);
        check_wave("clean", -1);
        tick;
        check("final_idle", tx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
